// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding and
// memory address-select codes.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ADDR   = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_DIR = 2'd1;
  localparam logic [1:0] ADDR_IND = 2'd2;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory-port handshake between the sequencer (master) and the
// memory (slave). mem_req is held until mem_ready completes the access.
interface cpu_sequencer_if;

  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_addr_sel;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );

endinterface

// File: rtl/cpu_sequencer_mem_watchdog.sv
// Memory-wait watchdog: counts stalled request cycles, flags a timeout on the
// MEM_TIMEOUT-th consecutive stall and latches a sticky error.
module cpu_sequencer_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic timeout,
  output logic err
);

  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic             waiting;

  assign waiting = mem_req & ~mem_ready;

  // Fires on the stall cycle that would bring the count up to MEM_TIMEOUT.
  assign timeout = waiting && (count_reg == CNT_W'(MEM_TIMEOUT - 1));
  assign err     = err_reg;

  // Count clears whenever the request completes or is not asserted,
  // so a MEM->FETCH hand-over starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (waiting) begin
        count_reg <= count_reg + CNT_W'(1);
      end else begin
        count_reg <= '0;
      end
      err_reg <= err_reg | timeout;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/addr/exec/mem/wb control.
// Optional memory watchdog enabled by defining SEQ_WATCHDOG_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dec_mem_write,
  input  logic                   dec_reg_write,
  input  logic                   dec_alu_en,
  input  logic                   dec_jmp,
  input  logic                   dec_jmp_if,
  input  logic                   dec_load_imm,
  input  logic                   dec_load_ind,
  input  logic                   dec_store_ind,
  input  logic                   dec_mem_reg,
  input  logic                   dec_halt,
  input  logic                   alu_flag,
  cpu_sequencer_if.master        mem,
  output logic                   ir_load,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   mar_load,
  output logic                   alu_go,
  output logic                   reg_we,
  output logic                   halted,
  output logic                   err,
  output logic [2:0]             state
);

  state_t state_reg;
  state_t state_next;
  logic   timeout;
  logic   is_store;
  logic   is_ind;
  logic   unused_flags;

  if (MEM_TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("MEM_TIMEOUT must be below 2**CNT_W");
  end

  assign is_store = dec_mem_write | dec_store_ind;
  assign is_ind   = dec_load_ind | dec_store_ind;
  assign state    = state_reg;

  // Register writes are always issued through WB, so the decoded flag is redundant.
  assign unused_flags = dec_reg_write;

`ifdef SEQ_WATCHDOG_EN
  cpu_sequencer_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem.mem_req),
    .mem_ready (mem.mem_ready),
    .timeout   (timeout),
    .err       (err)
  );
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (timeout)            state_next = S_HALT;
        else if (mem.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt)                         state_next = S_HALT;
        else if (dec_jmp)                     state_next = S_FETCH;
        else if (is_ind)                      state_next = S_ADDR;
        else if (dec_mem_reg | dec_mem_write) state_next = S_MEM;
        else if (dec_alu_en)                  state_next = S_EXEC;
        else if (dec_load_imm)                state_next = S_WB;
        else                                  state_next = S_FETCH;
      end
      S_ADDR: state_next = S_MEM;
      S_EXEC: begin
        state_next = dec_jmp_if ? S_FETCH : S_WB;
      end
      S_MEM: begin
        if (timeout)            state_next = S_HALT;
        else if (mem.mem_ready) state_next = is_store ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = ADDR_PC;
    ir_load          = 1'b0;
    pc_inc           = 1'b0;
    pc_load          = 1'b0;
    mar_load         = 1'b0;
    alu_go           = 1'b0;
    reg_we           = 1'b0;
    halted           = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_load     = mem.mem_ready;
        pc_inc      = mem.mem_ready;
      end
      S_DECODE: begin
        pc_load = ~dec_halt & dec_jmp;
      end
      S_ADDR: begin
        mar_load = 1'b1;
      end
      S_EXEC: begin
        alu_go  = 1'b1;
        pc_load = dec_jmp_if & alu_flag;
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_we       = is_store;
        mem.mem_addr_sel = is_ind ? ADDR_IND : ADDR_DIR;
      end
      S_WB: begin
        reg_we = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: cycle-by-cycle expected output vectors.
// Watchdog scenario follows SEQ_WATCHDOG_EN.
module tb_cpu_sequencer;

  localparam logic [11:0] O_NONE = 12'b0000_0000_0000;
  localparam logic [11:0] O_REQ  = 12'b1000_0000_0000;
  localparam logic [11:0] O_WE   = 12'b0100_0000_0000;
  localparam logic [11:0] O_IND  = 12'b0010_0000_0000;
  localparam logic [11:0] O_DIR  = 12'b0001_0000_0000;
  localparam logic [11:0] O_IR   = 12'b0000_1000_0000;
  localparam logic [11:0] O_PCI  = 12'b0000_0100_0000;
  localparam logic [11:0] O_PCL  = 12'b0000_0010_0000;
  localparam logic [11:0] O_MAR  = 12'b0000_0001_0000;
  localparam logic [11:0] O_ALU  = 12'b0000_0000_1000;
  localparam logic [11:0] O_RWE  = 12'b0000_0000_0100;
  localparam logic [11:0] O_HLT  = 12'b0000_0000_0010;
  localparam logic [11:0] O_ERR  = 12'b0000_0000_0001;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FET  = 3'd1;
  localparam logic [2:0] ST_DEC  = 3'd2;
  localparam logic [2:0] ST_ADR  = 3'd3;
  localparam logic [2:0] ST_EXE  = 3'd4;
  localparam logic [2:0] ST_MEM  = 3'd5;
  localparam logic [2:0] ST_WB   = 3'd6;
  localparam logic [2:0] ST_HLT  = 3'd7;

  logic clk;
  logic rst_n;
  logic start;
  logic dec_mem_write, dec_reg_write, dec_alu_en, dec_jmp, dec_jmp_if;
  logic dec_load_imm, dec_load_ind, dec_store_ind, dec_mem_reg, dec_halt;
  logic alu_flag;
  logic ir_load, pc_inc, pc_load, mar_load, alu_go, reg_we, halted, err;
  logic [2:0] state;
  logic [14:0] obs;

  int checks;
  int errors;

  cpu_sequencer_if mem_bus ();

  cpu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dec_mem_write (dec_mem_write),
    .dec_reg_write (dec_reg_write),
    .dec_alu_en    (dec_alu_en),
    .dec_jmp       (dec_jmp),
    .dec_jmp_if    (dec_jmp_if),
    .dec_load_imm  (dec_load_imm),
    .dec_load_ind  (dec_load_ind),
    .dec_store_ind (dec_store_ind),
    .dec_mem_reg   (dec_mem_reg),
    .dec_halt      (dec_halt),
    .alu_flag      (alu_flag),
    .mem           (mem_bus),
    .ir_load       (ir_load),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .mar_load      (mar_load),
    .alu_go        (alu_go),
    .reg_we        (reg_we),
    .halted        (halted),
    .err           (err),
    .state         (state)
  );

  assign obs = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr_sel,
                ir_load, pc_inc, pc_load, mar_load, alu_go, reg_we,
                halted, err, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ex(input logic [2:0] st, input logic [11:0] f);
    return {f, st};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; drives inputs, samples mid-cycle, advances.
  task automatic cyc(input string tag, input logic rdy, input logic flg,
                     input logic [14:0] exp);
    mem_bus.mem_ready = rdy;
    alu_flag          = flg;
    #2;
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic mw, input logic rw, input logic alu,
                         input logic jmp, input logic jif, input logic limm,
                         input logic lind, input logic sind, input logic mreg,
                         input logic hlt);
    dec_mem_write = mw;
    dec_reg_write = rw;
    dec_alu_en    = alu;
    dec_jmp       = jmp;
    dec_jmp_if    = jif;
    dec_load_imm  = limm;
    dec_load_ind  = lind;
    dec_store_ind = sind;
    dec_mem_reg   = mreg;
    dec_halt      = hlt;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    start             = 1'b1;
    alu_flag          = 1'b0;
    mem_bus.mem_ready = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with start and mem_ready high: everything stays 0.
    repeat (2) @(posedge clk);
    #3;
    check("rst_hold", obs, ex(ST_IDLE, O_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    cyc("idle_wait", 1, 0, ex(ST_IDLE, O_NONE));
    start = 1'b1;
    cyc("idle_start", 1, 0, ex(ST_IDLE, O_NONE));
    start = 1'b0;
    $display("TXN reset/start");

    set_dec(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("alu_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("alu_dec",   1, 0, ex(ST_DEC, O_NONE));
    cyc("alu_exec",  0, 0, ex(ST_EXE, O_ALU));
    cyc("alu_wb",    0, 0, ex(ST_WB, O_RWE));
    $display("TXN alu op");

    set_dec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("sti_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("sti_dec",   0, 0, ex(ST_DEC, O_NONE));
    cyc("sti_addr",  0, 0, ex(ST_ADR, O_MAR));
    cyc("sti_mem0",  0, 0, ex(ST_MEM, O_REQ | O_WE | O_IND));
    cyc("sti_mem1",  0, 0, ex(ST_MEM, O_REQ | O_WE | O_IND));
    cyc("sti_mem2",  1, 0, ex(ST_MEM, O_REQ | O_WE | O_IND));
    $display("TXN indirect store, 2 waits");

    set_dec(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("ld_fwait",  0, 0, ex(ST_FET, O_REQ));
    cyc("ld_fetch",  1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("ld_dec",    0, 0, ex(ST_DEC, O_NONE));
    cyc("ld_mem",    1, 0, ex(ST_MEM, O_REQ | O_DIR));
    cyc("ld_wb",     0, 0, ex(ST_WB, O_RWE));
    $display("TXN direct load, 1 fetch wait");

    set_dec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc("jif1_fetch", 1, 1, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("jif1_dec",   0, 1, ex(ST_DEC, O_NONE));
    cyc("jif1_exec",  0, 1, ex(ST_EXE, O_ALU | O_PCL));
    $display("TXN jmp_if taken");
    cyc("jif0_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("jif0_dec",   0, 0, ex(ST_DEC, O_NONE));
    cyc("jif0_exec",  0, 0, ex(ST_EXE, O_ALU));
    $display("TXN jmp_if not taken");

    set_dec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("jmp_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("jmp_dec",   0, 0, ex(ST_DEC, O_PCL));
    $display("TXN jmp");

    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("nop_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("nop_dec",   1, 0, ex(ST_DEC, O_NONE));
    $display("TXN nop");

    set_dec(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc("imm_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("imm_dec",   0, 0, ex(ST_DEC, O_NONE));
    cyc("imm_wb",    0, 0, ex(ST_WB, O_RWE));
    $display("TXN load imm");

    // Halt wins over jmp; start pulses are ignored outside IDLE.
    set_dec(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    cyc("hlt_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("hlt_dec",   1, 0, ex(ST_DEC, O_NONE));
    cyc("hlt_0",     1, 0, ex(ST_HLT, O_HLT));
    cyc("hlt_1",     1, 0, ex(ST_HLT, O_HLT));
    start = 1'b0;
    cyc("hlt_2",     1, 0, ex(ST_HLT, O_HLT));
    rst_n = 1'b0;
    #1;
    check("hlt_rst", obs, ex(ST_IDLE, O_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    cyc("hlt_restart", 1, 0, ex(ST_IDLE, O_NONE));
    start = 1'b0;
    $display("TXN halt");

    // Asynchronous reset in the middle of a MEM wait.
    set_dec(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("arst_fetch", 1, 0, ex(ST_FET, O_REQ | O_IR | O_PCI));
    cyc("arst_dec",   0, 0, ex(ST_DEC, O_NONE));
    mem_bus.mem_ready = 1'b0;
    #2;
    check("arst_mem", obs, ex(ST_MEM, O_REQ | O_DIR));
    rst_n = 1'b0;
    #1;
    check("arst_drop", obs, ex(ST_IDLE, O_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("arst_idle", 1, 0, ex(ST_IDLE, O_NONE));
    start = 1'b1;
    cyc("arst_start", 1, 0, ex(ST_IDLE, O_NONE));
    start = 1'b0;
    $display("TXN reset mid-MEM");

    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SEQ_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      cyc("wd_wait", 0, 0, ex(ST_FET, O_REQ));
    end
    cyc("wd_halt",   0, 0, ex(ST_HLT, O_HLT | O_ERR));
    cyc("wd_sticky", 1, 0, ex(ST_HLT, O_HLT | O_ERR));
    $display("TXN watchdog timeout");
`else
    for (int i = 0; i < 100; i++) begin
      cyc("nowd_wait", 0, 0, ex(ST_FET, O_REQ));
    end
    $display("TXN no watchdog, stalled fetch");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
